// File: rtl/data_bus_responder_pkg.sv
// data_bus_responder_pkg: shared MMIO map, CTRL bit positions and decode region type
package data_bus_responder_pkg;
  localparam logic [2:0] MMIO_GPIO  = 3'd0;
  localparam logic [2:0] MMIO_COUNT = 3'd1;
  localparam logic [2:0] MMIO_CMP   = 3'd2;
  localparam logic [2:0] MMIO_CTRL  = 3'd3;
  localparam logic [2:0] MMIO_ERR   = 3'd4;
  localparam int CTRL_TEN  = 0;
  localparam int CTRL_PEND = 1;
  localparam int CTRL_IEN  = 2;
  typedef enum logic [1:0] {REGION_RAM, REGION_MMIO, REGION_NONE} region_e;
endpackage

// File: rtl/timer_unit.sv
// timer_unit: free-running COUNT, CMP compare and CTRL pending/enable logic
module timer_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [2:0]   offset,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         irq
);
  import data_bus_responder_pkg::*;
  logic [W-1:0] count, cmp;
  logic ten, pend, ien, wr_count, wr_cmp, wr_ctrl, match;
  assign wr_count = wr_en && offset == MMIO_COUNT;
  assign wr_cmp   = wr_en && offset == MMIO_CMP;
  assign wr_ctrl  = wr_en && offset == MMIO_CTRL;
  assign match    = ten && count == cmp;
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      cmp   <= '1;
      ten   <= 1'b0;
      pend  <= 1'b0;
      ien   <= 1'b0;
    end else begin
      count <= wr_count ? wr_data : count + W'(1);
      cmp   <= wr_cmp ? wr_data : cmp;
      ten   <= wr_ctrl ? wr_data[CTRL_TEN] : ten;
      ien   <= wr_ctrl ? wr_data[CTRL_IEN] : ien;
      // a compare hit beats a simultaneous write-1-to-clear
      pend  <= match | (pend & ~(wr_ctrl & wr_data[CTRL_PEND]));
    end
  end
  always_comb begin
    rd_data = offset == MMIO_COUNT ? count :
              offset == MMIO_CMP   ? cmp :
              offset == MMIO_CTRL  ? W'({ien, pend, ten}) : '0;
  end
  assign irq = pend & ien;
endmodule

// File: rtl/data_bus_responder.sv
// data_bus_responder: data-memory slave with word RAM, GPIO, timer and sticky address-error flag
module data_bus_responder #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  RAM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE = 32'h8000_0000,
  parameter int                  GPIO_WIDTH = 8
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic [ADDR_WIDTH-1:0] i_MemAddr,
  input  logic                  i_MemWrEnable,
  input  logic [DATA_WIDTH-1:0] i_MemWrData,
  output logic [DATA_WIDTH-1:0] o_MemRdData,
  output logic [GPIO_WIDTH-1:0] o_GpioOut,
  output logic                  o_TimerIrq,
  output logic                  o_AddrError
);
  import data_bus_responder_pkg::*;
  localparam int IW = $clog2(RAM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] RAM_BYTES = ADDR_WIDTH'(RAM_WORDS * 4);
  logic [DATA_WIDTH-1:0] ram [RAM_WORDS];
  logic [DATA_WIDTH-1:0] timer_rd, mmio_rd;
  logic [IW-1:0] idx;
  logic [2:0] offset;
  logic mmio_wr;
  region_e region;
  assign idx    = i_MemAddr[IW+1:2];
  assign offset = i_MemAddr[4:2];
  always_comb begin
    region = i_MemAddr < RAM_BYTES ? REGION_RAM :
             i_MemAddr[ADDR_WIDTH-1:5] == MMIO_BASE[ADDR_WIDTH-1:5] ? REGION_MMIO : REGION_NONE;
  end
  assign mmio_wr = i_MemWrEnable && region == REGION_MMIO;
  always_ff @(posedge i_Clock) begin
    if (!i_Reset && i_MemWrEnable && region == REGION_RAM) ram[idx] <= i_MemWrData;
  end
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_GpioOut   <= '0;
      o_AddrError <= 1'b0;
    end else begin
      o_GpioOut   <= mmio_wr && offset == MMIO_GPIO ? i_MemWrData[GPIO_WIDTH-1:0] : o_GpioOut;
      // clearing via ERR outranks setting, though the two cannot coincide
      o_AddrError <= mmio_wr && offset == MMIO_ERR ? 1'b0 :
                     i_MemWrEnable && region == REGION_NONE ? 1'b1 : o_AddrError;
    end
  end
  timer_unit #(.W(DATA_WIDTH)) u_timer (
    .clk     (i_Clock),
    .rst     (i_Reset),
    .wr_en   (mmio_wr),
    .offset  (offset),
    .wr_data (i_MemWrData),
    .rd_data (timer_rd),
    .irq     (o_TimerIrq)
  );
  always_comb begin
    mmio_rd = offset == MMIO_GPIO ? DATA_WIDTH'(o_GpioOut) :
              offset == MMIO_ERR  ? DATA_WIDTH'(o_AddrError) : timer_rd;
    o_MemRdData = region == REGION_RAM  ? ram[idx] :
                  region == REGION_MMIO ? mmio_rd : '0;
  end
endmodule

// File: tb/tb_data_bus_responder.sv
// tb_data_bus_responder: directed self-checking bench for data_bus_responder
module tb_data_bus_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  gpio;
  logic        irq, aerr;
  int checks = 0;
  int errors = 0;
  logic [31:0] d;

  localparam logic [31:0] A_GPIO  = 32'h8000_0000;
  localparam logic [31:0] A_COUNT = 32'h8000_0004;
  localparam logic [31:0] A_CMP   = 32'h8000_0008;
  localparam logic [31:0] A_CTRL  = 32'h8000_000C;
  localparam logic [31:0] A_ERR   = 32'h8000_0010;

  data_bus_responder dut (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_MemAddr     (addr),
    .i_MemWrEnable (we),
    .i_MemWrData   (wdata),
    .o_MemRdData   (rdata),
    .o_GpioOut     (gpio),
    .o_TimerIrq    (irq),
    .o_AddrError   (aerr)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    addr = a; wdata = v; we = 1'b1;
    cyc();
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    cyc();
    cyc();
    rst = 1'b0;
    // reset state and counter start
    chk("rst_gpio", 32'(gpio), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_err", 32'(aerr), 32'h0);
    rd(A_COUNT, d); chk("count_c0", d, 32'd0);
    rd(A_CMP, d);   chk("rst_cmp", d, 32'hFFFF_FFFF);
    rd(A_CTRL, d);  chk("rst_ctrl", d, 32'h0);
    cyc(); rd(A_COUNT, d); chk("count_c1", d, 32'd1);
    cyc(); rd(A_COUNT, d); chk("count_c2", d, 32'd2);

    // RAM write then read
    wr(32'h0000_0000, 32'h0);
    wr(32'h0000_0020, 32'h0);
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, d); chk("ram_rd", d, 32'hDEAD_BEEF);
    rd(32'h0000_0013, d); chk("ram_rd_lowbits", d, 32'hDEAD_BEEF);
    addr = 32'h10; wdata = 32'h1111_2222; we = 1'b1;
    #1 chk("ram_read_before_write", rdata, 32'hDEAD_BEEF);
    cyc(); we = 1'b0;
    rd(32'h0000_0010, d); chk("ram_rd_new", d, 32'h1111_2222);
    wr(32'h0000_0010, 32'hDEAD_BEEF);

    // GPIO
    wr(A_GPIO, 32'h1A5);
    chk("gpio_out", 32'(gpio), 32'hA5);
    rd(A_GPIO, d); chk("gpio_rd", d, 32'h0000_00A5);

    // counter wrap
    wr(A_COUNT, 32'hFFFF_FFFE);
    rd(A_COUNT, d); chk("count_fe", d, 32'hFFFF_FFFE);
    cyc(); rd(A_COUNT, d); chk("count_ff", d, 32'hFFFF_FFFF);
    cyc(); rd(A_COUNT, d); chk("count_wrap", d, 32'h0);

    // timer interrupt
    wr(A_CMP, 32'd20);
    wr(A_COUNT, 32'd0);
    wr(A_CTRL, 32'h5);
    for (int i = 0; i < 50; i++) begin
      rd(A_COUNT, d);
      if (d == 32'd20) break;
      cyc();
    end
    chk("count_reach_cmp", d, 32'd20);
    chk("irq_before_match_edge", 32'(irq), 32'h0);
    cyc();
    chk("irq_after_match", 32'(irq), 32'h1);
    rd(A_CTRL, d); chk("ctrl_pend", d, 32'h7);
    wr(A_CTRL, 32'h7);
    chk("irq_w1c", 32'(irq), 32'h0);
    rd(A_CTRL, d); chk("ctrl_cleared", d, 32'h5);
    wr(A_COUNT, 32'd20);
    wr(A_CTRL, 32'h7);
    chk("irq_set_beats_w1c", 32'(irq), 32'h1);
    wr(A_CTRL, 32'h2);
    chk("irq_off", 32'(irq), 32'h0);

    // address error
    wr(32'h4000_0000, 32'h5555_5555);
    chk("aerr_set", 32'(aerr), 32'h1);
    rd(32'h4000_0000, d); chk("unmapped_rd", d, 32'h0);
    rd(32'h0000_0000, d); chk("ram0_unchanged", d, 32'h0);
    rd(32'h0000_0010, d); chk("ram10_unchanged", d, 32'hDEAD_BEEF);
    chk("gpio_unchanged", 32'(gpio), 32'hA5);
    rd(A_ERR, d); chk("err_rd", d, 32'h1);
    wr(32'h8000_0014, 32'hFFFF_FFFF);
    rd(32'h8000_0014, d); chk("reserved_rd", d, 32'h0);
    chk("reserved_no_err_change", 32'(aerr), 32'h1);
    wr(A_ERR, 32'h0);
    chk("aerr_clear", 32'(aerr), 32'h0);
    rd(32'h4000_0000, d);
    cyc();
    chk("read_no_err", 32'(aerr), 32'h0);

    // reset mid-operation
    wr(A_GPIO, 32'hFF);
    wr(A_CMP, 32'd100);
    wr(A_CTRL, 32'h5);
    wr(A_COUNT, 32'd100);
    cyc();
    chk("pre_rst_irq", 32'(irq), 32'h1);
    wr(32'h4000_0000, 32'h0);
    chk("pre_rst_err", 32'(aerr), 32'h1);
    rst = 1'b1;
    wr(32'h0000_0020, 32'h1234);
    rst = 1'b0;
    chk("post_rst_gpio", 32'(gpio), 32'h0);
    chk("post_rst_irq", 32'(irq), 32'h0);
    chk("post_rst_err", 32'(aerr), 32'h0);
    rd(A_COUNT, d); chk("post_rst_count0", d, 32'h0);
    rd(A_CTRL, d);  chk("post_rst_ctrl", d, 32'h0);
    rd(A_CMP, d);   chk("post_rst_cmp", d, 32'hFFFF_FFFF);
    rd(32'h0000_0020, d); chk("post_rst_ram", d, 32'h0);
    cyc();
    rd(A_COUNT, d); chk("post_rst_count1", d, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
